// File: rtl/mmio_uart_pkg.sv
// Shared register map, STATUS bit positions and transmit FSM encoding for the MMIO UART.
package mmio_uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // A divisor below 2 cannot produce a usable bit period.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered pointers, combinational head; pushes/pops take effect at the clock edge.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 transmit UART: bus write -> FIFO next edge -> TXD start bit one edge later; reads return next cycle.
// No bus backpressure: pushes into a full FIFO are dropped and flagged in OVERRUN. Macro MMIO_UART_TX_DIV_WR_EN makes DIV writable.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RDEN,
  input  logic [31:0] RIADDR,
  output logic [31:0] ROADDR,
  output logic        RVALID,
  output logic [31:0] RDATA,
  input  logic        WREN,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] WADDR,
  input  logic [31:0] WDATA,
  output logic        TXD,
  output logic        TX_IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e    state_q, state_d;
  logic [15:0]  timer_q, timer_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [2:0]   bitcnt_q, bitcnt_d;
  logic         txd_q, txd_d, irq_q, irq_d, overrun_q, overrun_d;
  logic         rvalid_q;
  logic [31:0]  roaddr_q, roaddr_d, rdata_q, rdata_d;
  logic [15:0]  div_val;

  logic         fifo_full, fifo_empty, pop, push_req, push_ok;
  logic [7:0]   fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [15:0]  cnt_ext;
  logic [31:0]  status_w;

  wire rd_hit = RDEN && (RIADDR[31:4] == BASE_ADDR[31:4]);
  wire wr_hit = WREN && (WADDR[31:4] == BASE_ADDR[31:4]);

  assign pop      = (state_q == S_IDLE) && !fifo_empty;
  assign push_req = wr_hit && (WADDR[3:0] == OFF_TXDATA) && WSTRB[0];
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok  = push_req && (!fifo_full || pop);
  assign overrun_d = (overrun_q && !(rd_hit && RIADDR[3:0] == OFF_STATUS)) || (push_req && !push_ok);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push_ok),
    .din_i   (WDATA[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef MMIO_UART_TX_DIV_WR_EN
  logic [15:0] div_q, div_d;
  always_comb begin
    div_d = div_q;
    if (wr_hit && WADDR[3:0] == OFF_DIV && WSTRB[1:0] == 2'b11) div_d = clamp_div(WDATA[15:0]);
  end
  always_ff @(posedge CLK) begin
    if (!RST) div_q <= CLK_DIV;
    else      div_q <= div_d;
  end
  assign div_val = div_q;
`else
  assign div_val = CLK_DIV;
`endif

  assign cnt_ext = 16'(fifo_count);

  always_comb begin
    status_w = '0;
    status_w[ST_FULL]    = fifo_full;
    status_w[ST_EMPTY]   = fifo_empty;
    status_w[ST_BUSY]    = (state_q != S_IDLE);
    status_w[ST_OVERRUN] = overrun_q;
    status_w[ST_CNT_LSB +: 8] = cnt_ext[7:0];
  end

  always_comb begin
    roaddr_d = roaddr_q;
    rdata_d  = rdata_q;
    if (rd_hit) begin
      roaddr_d = RIADDR;
      case (RIADDR[3:0])
        OFF_STATUS: rdata_d = status_w;
        OFF_DIV:    rdata_d = {16'h0, div_val};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_START;
          shreg_d = fifo_dout;
          timer_d = div_val - 16'd1;
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          state_d  = S_DATA;
          timer_d  = div_val - 16'd1;
          bitcnt_d = '0;
        end else timer_d = timer_q - 16'd1;
      end
      S_DATA: begin
        if (timer_q == '0) begin
          timer_d = div_val - 16'd1;
          if (bitcnt_q == 3'd7) state_d = S_STOP;
          else begin
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else timer_d = timer_q - 16'd1;
      end
      default: begin
        if (timer_q == '0) state_d = S_IDLE;
        else timer_d = timer_q - 16'd1;
      end
    endcase
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    irq_d = fifo_empty && (state_q == S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b1;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
      roaddr_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
      overrun_q <= overrun_d;
      rvalid_q  <= rd_hit;
      roaddr_q  <= roaddr_d;
      rdata_q   <= rdata_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{WDATA[31:8], WSTRB[3:1], cnt_ext[15:8]};

  assign RVALID = rvalid_q;
  assign ROADDR = roaddr_q;
  assign RDATA  = rdata_q;
  assign TXD    = txd_q;
  assign TX_IRQ = irq_q;

endmodule
